id_stage_reg: RTL and testbench

- ID/EX pipeline register sitting directly downstream of the decode-stage control unit.
- Captures the decoded control word (exec command, mem_read, mem_write, wb_en, branch, status_update_en) plus operands, immediates, destination and PC each cycle, and presents them to the EX stage.
- Implements pipeline freeze (hazard stall), flush (taken branch) and bubble insertion, with a valid bit tracking whether EX holds a real instruction.

---
 rtl/id_stage_reg_pkg.sv | 34 +++
 rtl/id_stage_reg_pipe_field.sv | 24 ++
 rtl/id_stage_reg.sv | 121 ++++++++++++
 tb/tb_id_stage_reg.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: field widths, control-bit
// literals and the execute-command encodings produced by the control unit.
package id_stage_reg_pkg;

  localparam int EXECUTE_COMMAND_LEN = 4;
  localparam int REG_ADDR_LEN        = 4;
  localparam int SHIFT_OPERAND_LEN   = 12;
  localparam int SIGNED_IMM_LEN      = 24;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  // Execute-command encodings; memory ops and compares reuse the ALU codes.
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_NOP = 4'b0000;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_MOV = 4'b0001;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_MVN = 4'b1001;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_ADD = 4'b0010;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_ADC = 4'b0011;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_SUB = 4'b0100;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_SBC = 4'b0101;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_AND = 4'b0110;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_ORR = 4'b0111;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_EOR = 4'b1000;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_CMP = EXEC_SUB;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_TST = EXEC_AND;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_LDR = EXEC_ADD;
  localparam logic [EXECUTE_COMMAND_LEN-1:0] EXEC_STR = EXEC_ADD;

  // A side-effecting control bit only survives when the instruction is real.
  function automatic logic ctrl_gate(input logic valid, input logic bit_in);
    return valid ? bit_in : ZERO;
  endfunction

endpackage

// File: rtl/id_stage_reg_pipe_field.sv
// Generic pipeline register slice: sync active-low reset, then clear (bubble),
// then hold (stall), otherwise load. Reset and clear both drive zero.
module pipe_field #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register with freeze, flush and bubble gating of control bits.
// Build with FORWARDING_EN defined to carry source register addresses to EX.
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = REG_ADDR_LEN,
  parameter int EXEC_W     = EXECUTE_COMMAND_LEN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         flush,
  input  logic                         id_valid,
  input  logic [EXEC_W-1:0]            exec_command_in,
  input  logic                         mem_read_in,
  input  logic                         mem_write_in,
  input  logic                         wb_en_in,
  input  logic                         branch_in,
  input  logic                         status_update_en_in,
  input  logic [DATA_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            val_rn_in,
  input  logic [DATA_W-1:0]            val_rm_in,
  input  logic                         imm_in,
  input  logic [SHIFT_OPERAND_LEN-1:0] shift_operand_in,
  input  logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0]        dest_in,
  input  logic                         carry_in,
`ifdef FORWARDING_EN
  input  logic [REG_ADDR_W-1:0]        src1_in,
  input  logic [REG_ADDR_W-1:0]        src2_in,
  output logic [REG_ADDR_W-1:0]        src1_out,
  output logic [REG_ADDR_W-1:0]        src2_out,
`endif
  output logic                         ex_valid,
  output logic [EXEC_W-1:0]            exec_command_out,
  output logic                         mem_read_out,
  output logic                         mem_write_out,
  output logic                         wb_en_out,
  output logic                         branch_out,
  output logic                         status_update_en_out,
  output logic [DATA_W-1:0]            pc_out,
  output logic [DATA_W-1:0]            val_rn_out,
  output logic [DATA_W-1:0]            val_rm_out,
  output logic                         imm_out,
  output logic [SHIFT_OPERAND_LEN-1:0] shift_operand_out,
  output logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_out,
  output logic [REG_ADDR_W-1:0]        dest_out,
  output logic                         carry_out
);

  // Handshake: ex_valid=1 means EX holds a real instruction for this cycle;
  // there is no back-pressure path, freeze is the only stall.
  localparam int CTRL_W = 1 + EXEC_W + 5;
  localparam int DP_W   = 3 * DATA_W + 1 + SHIFT_OPERAND_LEN + SIGNED_IMM_LEN
                          + REG_ADDR_W + 1;

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DP_W-1:0]   dp_d, dp_q;

  // exec_command is not side-effecting on its own, so only the five
  // enables are gated by id_valid on a load.
  assign ctrl_d = {id_valid,
                   exec_command_in,
                   ctrl_gate(id_valid, mem_read_in),
                   ctrl_gate(id_valid, mem_write_in),
                   ctrl_gate(id_valid, wb_en_in),
                   ctrl_gate(id_valid, branch_in),
                   ctrl_gate(id_valid, status_update_en_in)};

  assign dp_d = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                 signed_imm_24_in, dest_in, carry_in};

  pipe_field #(.WIDTH(CTRL_W)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .hold  (freeze),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_field #(.WIDTH(DP_W)) u_dp (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .hold  (freeze),
    .d     (dp_d),
    .q     (dp_q)
  );

  assign {ex_valid,
          exec_command_out,
          mem_read_out,
          mem_write_out,
          wb_en_out,
          branch_out,
          status_update_en_out} = ctrl_q;

  assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
          signed_imm_24_out, dest_out, carry_out} = dp_q;

`ifdef FORWARDING_EN
  logic [2*REG_ADDR_W-1:0] src_d, src_q;

  // Immediate forms have no Rm, so a zero src2 avoids false forwarding hits.
  assign src_d = {src1_in, imm_in ? {REG_ADDR_W{ZERO}} : src2_in};

  pipe_field #(.WIDTH(2 * REG_ADDR_W)) u_src (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .hold  (freeze),
    .d     (src_d),
    .q     (src_q)
  );

  assign {src1_out, src2_out} = src_q;
`endif

endmodule

// File: tb/tb_id_stage_reg.sv
// Self-checking bench for id_stage_reg: directed cases then random traffic,
// scored against a rule-level model through an expected-value queue.
module tb_id_stage_reg;
  import id_stage_reg_pkg::*;

  typedef struct packed {
    logic        ex_valid;
    logic [3:0]  exec_command;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic        branch;
    logic        status_update_en;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic        carry;
`ifdef FORWARDING_EN
    logic [3:0]  src1;
    logic [3:0]  src2;
`endif
  } rec_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, id_valid;
  rec_t in_r, act, model_state;
  rec_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUT ----------------
  id_stage_reg dut (
    .clk                  (clk),
    .rst                  (rst),
    .freeze               (freeze),
    .flush                (flush),
    .id_valid             (id_valid),
    .exec_command_in      (in_r.exec_command),
    .mem_read_in          (in_r.mem_read),
    .mem_write_in         (in_r.mem_write),
    .wb_en_in             (in_r.wb_en),
    .branch_in            (in_r.branch),
    .status_update_en_in  (in_r.status_update_en),
    .pc_in                (in_r.pc),
    .val_rn_in            (in_r.val_rn),
    .val_rm_in            (in_r.val_rm),
    .imm_in               (in_r.imm),
    .shift_operand_in     (in_r.shift_operand),
    .signed_imm_24_in     (in_r.signed_imm_24),
    .dest_in              (in_r.dest),
    .carry_in             (in_r.carry),
`ifdef FORWARDING_EN
    .src1_in              (in_r.src1),
    .src2_in              (in_r.src2),
    .src1_out             (act.src1),
    .src2_out             (act.src2),
`endif
    .ex_valid             (act.ex_valid),
    .exec_command_out     (act.exec_command),
    .mem_read_out         (act.mem_read),
    .mem_write_out        (act.mem_write),
    .wb_en_out            (act.wb_en),
    .branch_out           (act.branch),
    .status_update_en_out (act.status_update_en),
    .pc_out               (act.pc),
    .val_rn_out           (act.val_rn),
    .val_rm_out           (act.val_rm),
    .imm_out              (act.imm),
    .shift_operand_out    (act.shift_operand),
    .signed_imm_24_out    (act.signed_imm_24),
    .dest_out             (act.dest),
    .carry_out            (act.carry)
  );

  // ---------------- reference model ----------------
  function automatic rec_t model_next(rec_t prev, logic r_n, logic fl, logic fz,
                                      logic idv, rec_t in);
    rec_t n;
    if (!r_n || fl) begin
      n = '0;
    end else if (fz) begin
      n = prev;
    end else begin
      n = in;
      n.ex_valid = idv;
      if (!idv) begin
        n.mem_read = 1'b0;
        n.mem_write = 1'b0;
        n.wb_en = 1'b0;
        n.branch = 1'b0;
        n.status_update_en = 1'b0;
      end
`ifdef FORWARDING_EN
      if (in.imm) n.src2 = 4'd0;
`endif
    end
    return n;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r = '0;
    r.exec_command     = 4'($urandom_range(0, 15));
    r.mem_read         = 1'($urandom_range(0, 1));
    r.mem_write        = 1'($urandom_range(0, 1));
    r.wb_en            = 1'($urandom_range(0, 1));
    r.branch           = 1'($urandom_range(0, 1));
    r.status_update_en = 1'($urandom_range(0, 1));
    r.pc               = $urandom;
    r.val_rn           = $urandom;
    r.val_rm           = $urandom;
    r.imm              = 1'($urandom_range(0, 1));
    r.shift_operand    = 12'($urandom);
    r.signed_imm_24    = 24'($urandom);
    r.dest             = 4'($urandom_range(0, 15));
    r.carry            = 1'($urandom_range(0, 1));
`ifdef FORWARDING_EN
    r.src1             = 4'($urandom_range(0, 15));
    r.src2             = 4'($urandom_range(0, 15));
`endif
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r_n, input logic fl, input logic fz,
                      input logic idv, input rec_t in);
    rec_t e;
    @(negedge clk);
    rst = r_n;
    flush = fl;
    freeze = fz;
    id_valid = idv;
    in_r = in;
    e = model_next(model_state, r_n, fl, fz, idv, in);
    model_state = e;
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    rec_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle=%0d actual=%h required=%h", cyc, act, e);
      end
      checks++;
      if (!act.ex_valid && (act.mem_read | act.mem_write | act.wb_en |
                            act.branch | act.status_update_en) !== 1'b0) begin
        errors++;
        $display("FAIL ctrl_without_valid cycle=%0d actual=%b required=00000", cyc,
                 {act.mem_read, act.mem_write, act.wb_en, act.branch, act.status_update_en});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rec_t s;
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; id_valid = 1'b0;
    in_r = '0;
    model_state = '0;

    // reset with every input high, then release: first edge loads
    s = '1;
    step(1'b0, 1'b1, 1'b1, 1'b1, s);
    step(1'b0, 1'b1, 1'b1, 1'b1, s);
    step(1'b1, 1'b0, 1'b0, 1'b1, s);

    // plain ADD load
    s = '0;
    s.exec_command = EXEC_ADD; s.wb_en = 1'b1; s.val_rn = 32'h5; s.dest = 4'd3;
    step(1'b1, 1'b0, 1'b0, 1'b1, s);

    // LDR load then three frozen cycles with a changed PC
    s = '0;
    s.exec_command = EXEC_LDR; s.mem_read = 1'b1; s.wb_en = 1'b1; s.pc = 32'h10;
    step(1'b1, 1'b0, 1'b0, 1'b1, s);
    s.pc = 32'h20;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, s);
    step(1'b1, 1'b0, 1'b0, 1'b1, s);

    // flush wins over freeze on a STR
    s = '0;
    s.exec_command = EXEC_STR; s.mem_write = 1'b1; s.pc = 32'h44;
    step(1'b1, 1'b1, 1'b1, 1'b1, s);

    // bubble gating
    s = '0;
    s.wb_en = 1'b1; s.branch = 1'b1; s.dest = 4'd7;
    step(1'b1, 1'b0, 1'b0, 1'b0, s);

    // held flush produces consecutive bubbles
    s = rand_rec();
    step(1'b1, 1'b0, 1'b0, 1'b1, s);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, rand_rec());

`ifdef FORWARDING_EN
    s = '0;
    s.src1 = 4'd2; s.src2 = 4'd9; s.imm = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, s);
    s.imm = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1, s);
`endif

    // random traffic with occasional reset, flush and freeze runs
    for (int i = 0; i < 400; i++) begin
      logic r_n, fl, fz, idv;
      r_n = ($urandom_range(0, 49) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      fz  = ($urandom_range(0, 3) == 0);
      idv = ($urandom_range(0, 4) != 0);
      step(r_n, fl, fz, idv, rand_rec());
    end

    @(negedge clk);
    freeze = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
